// File: rtl/robot_anomaly_monitor_pkg.sv
// robot_anomaly_monitor_pkg: orientation, anomaly code and tracker state encodings
// shared by the monitor, the world model and the benches.
package robot_anomaly_monitor_pkg;
    typedef enum logic [1:0] {NORTH = 2'b00, SOUTH = 2'b01, EAST = 2'b10, WEST = 2'b11} orient_t;
    typedef enum logic [1:0] {ANOM_NONE = 2'd0, ANOM_MAP = 2'd1, ANOM_STEP = 2'd2, ANOM_STUCK = 2'd3} anom_t;
    typedef enum logic {EMPTY = 1'b0, TRACK = 1'b1} state_t;
endpackage

// File: rtl/robot_step_check.sv
// robot_step_check: classifies a position change against the reference cell and the
// reference orientation as same cell, one legal forward move, or illegal.
module robot_step_check
    import robot_anomaly_monitor_pkg::*;
#(
    parameter int POS_W = 6
) (
    input  logic [POS_W-1:0] ref_row,
    input  logic [POS_W-1:0] ref_column,
    input  logic [1:0]       ref_orientation,
    input  logic [POS_W-1:0] new_row,
    input  logic [POS_W-1:0] new_column,
    output logic             same_cell,
    output logic             legal_move,
    output logic             illegal
);
    logic [POS_W-1:0] exp_row, exp_column;
    assign exp_row    = ref_orientation == NORTH ? ref_row - POS_W'(1)
                      : ref_orientation == SOUTH ? ref_row + POS_W'(1) : ref_row;
    assign exp_column = ref_orientation == EAST ? ref_column + POS_W'(1)
                      : ref_orientation == WEST ? ref_column - POS_W'(1) : ref_column;
    assign same_cell  = new_row == ref_row && new_column == ref_column;
    assign legal_move = new_row == exp_row && new_column == exp_column;
    assign illegal    = !same_cell && !legal_move;
endmodule

// File: rtl/robot_anomaly_monitor.sv
// robot_anomaly_monitor: samples robot pose per move strobe, flags off-map, illegal-step and
// stuck anomalies in sticky flags, latches the first anomaly code and counts legal moves.
module robot_anomaly_monitor
    import robot_anomaly_monitor_pkg::*;
#(
    parameter int ROWS        = 10,
    parameter int COLS        = 20,
    parameter int POS_W       = 6,
    parameter int STUCK_LIMIT = 8,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sample,
    input  logic [POS_W-1:0] robot_row,
    input  logic [POS_W-1:0] robot_column,
    input  logic [1:0]       robot_orientation,
    input  logic             clear_alarms,
    output logic             out_of_map,
    output logic             illegal_step,
    output logic             stuck,
    output logic             anomaly,
    output logic [1:0]       anomaly_code,
    output logic [CNT_W-1:0] move_count
);
    localparam int SW = $clog2(STUCK_LIMIT + 1);
    state_t           state, state_nxt;
    logic [POS_W-1:0] ref_row, ref_column;
    logic [1:0]       ref_orientation, new_code, base_code;
    logic [SW-1:0]    stuck_cnt, stuck_cnt_nxt;
    logic in_map, tracking, same_cell, legal_move, illegal, same_all, hold;
    logic map_err, step_err, stuck_hit, move_ok, oom_nxt, ill_nxt, stk_nxt;

    robot_step_check #(.POS_W(POS_W)) u_step (
        .ref_row(ref_row), .ref_column(ref_column), .ref_orientation(ref_orientation),
        .new_row(robot_row), .new_column(robot_column),
        .same_cell(same_cell), .legal_move(legal_move), .illegal(illegal)
    );

    assign in_map   = robot_row != '0 && robot_row <= POS_W'(ROWS)
                   && robot_column != '0 && robot_column <= POS_W'(COLS);
    assign tracking = sample && in_map && state == TRACK;
    assign map_err  = sample && !in_map;
    assign step_err = tracking && illegal;
    assign move_ok  = tracking && legal_move;
    assign same_all = tracking && same_cell && robot_orientation == ref_orientation;
    // Once the limit is reached the counter parks there, so stuck fires only on arrival.
    assign hold     = same_all && stuck_cnt == SW'(STUCK_LIMIT);
    assign stuck_cnt_nxt = !sample ? stuck_cnt : !in_map ? '0 : hold ? stuck_cnt
                         : same_all ? stuck_cnt + SW'(1) : SW'(1);
    assign stuck_hit = sample && in_map && !hold && stuck_cnt_nxt == SW'(STUCK_LIMIT);
    assign new_code  = map_err ? ANOM_MAP : step_err ? ANOM_STEP : stuck_hit ? ANOM_STUCK : ANOM_NONE;
    assign base_code = clear_alarms ? ANOM_NONE : anomaly_code;
    assign oom_nxt   = map_err || (out_of_map && !clear_alarms);
    assign ill_nxt   = step_err || (illegal_step && !clear_alarms);
    assign stk_nxt   = stuck_hit || (stuck && !clear_alarms);

    always_comb begin
        state_nxt = state;
        if (sample) state_nxt = in_map ? TRACK : EMPTY;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= EMPTY;
            ref_row         <= '0;
            ref_column      <= '0;
            ref_orientation <= '0;
            stuck_cnt       <= '0;
            out_of_map      <= 1'b0;
            illegal_step    <= 1'b0;
            stuck           <= 1'b0;
            anomaly         <= 1'b0;
            anomaly_code    <= ANOM_NONE;
            move_count      <= '0;
        end else begin
            state        <= state_nxt;
            stuck_cnt    <= stuck_cnt_nxt;
            out_of_map   <= oom_nxt;
            illegal_step <= ill_nxt;
            stuck        <= stk_nxt;
            anomaly      <= oom_nxt || ill_nxt || stk_nxt;
            anomaly_code <= base_code == ANOM_NONE ? new_code : base_code;
            if (move_ok && !(&move_count)) move_count <= move_count + CNT_W'(1);
            if (sample && in_map) begin
                ref_row         <= robot_row;
                ref_column      <= robot_column;
                ref_orientation <= robot_orientation;
            end
        end
    end
endmodule
